// File: rtl/controlador_cache_2vias_pkg.sv
// cache_pkg: shared FSM states, tag-state bit-logic control codes and line-size default
// for the 2-way cache controller.
package cache_pkg;
    localparam int WORDS_LINE_DEF = 4;
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, FILLTAG, TOUCH, LRUCLR, DONE} estado_t;
    // {uso, sel_mux_mem_0, sel_mux_mem_1}
    localparam logic [2:0] RD_TOUCH = 3'b111;
    localparam logic [2:0] WR_TOUCH = 3'b110;
    localparam logic [2:0] FILL     = 3'b101;
    localparam logic [2:0] CLR_LRU  = 3'b001;
    localparam logic [2:0] HOLD     = 3'b000;
endpackage

// File: rtl/controlador_cache_2vias_contador_saturado.sv
// contador_saturado: enabled up-counter that sticks at all-ones instead of wrapping.
module contador_saturado #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/controlador_cache_2vias.sv
// controlador_cache_2vias: sequences lookup, dirty write-back, refill, LRU update and CPU
// response for a 2-way set-associative cache, driving the tag-state bit logic and array enables.
module controlador_cache_2vias
    import cache_pkg::*;
#(
    parameter int WORDS_LINE = WORDS_LINE_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    output logic                          cpu_ready,
    input  logic                          hit_0,
    input  logic                          hit_1,
    input  logic                          lru_0,
    input  logic                          dirty_0,
    input  logic                          dirty_1,
    output logic                          way_sel,
    output logic                          uso,
    output logic                          sel_mux_mem_0,
    output logic                          sel_mux_mem_1,
    output logic                          tag_we,
    output logic                          data_we,
    output logic                          mem_req,
    output logic                          mem_we,
    input  logic                          mem_ack,
    output logic [$clog2(WORDS_LINE)-1:0] beat,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt
);
    localparam int BW = $clog2(WORDS_LINE);
    localparam logic [BW-1:0] LAST = BW'(WORDS_LINE - 1);

    estado_t       estado_q, estado_d;
    logic          way_q, way_d, we_q, we_d, hit_en, miss_en;
    logic [BW-1:0] beat_q, beat_d;
    logic [2:0]    code;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            estado_q <= IDLE;
            way_q    <= 1'b0;
            we_q     <= 1'b0;
            beat_q   <= '0;
        end else begin
            estado_q <= estado_d;
            way_q    <= way_d;
            we_q     <= we_d;
            beat_q   <= beat_d;
        end

    // beat wraps to 0 after the last word since WORDS_LINE is a power of two
    always_comb begin
        estado_d  = estado_q;
        way_d     = way_q;
        we_d      = we_q;
        beat_d    = beat_q;
        code      = HOLD;
        tag_we    = 1'b0;
        data_we   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        hit_en    = 1'b0;
        miss_en   = 1'b0;
        unique case (estado_q)
            IDLE: if (cpu_req) begin
                we_d     = cpu_we;
                estado_d = LOOKUP;
            end
            LOOKUP: if (hit_0 || hit_1) begin
                way_d    = !hit_0;
                hit_en   = 1'b1;
                estado_d = TOUCH;
            end else begin
                way_d    = lru_0;
                miss_en  = 1'b1;
                beat_d   = '0;
                estado_d = (lru_0 ? dirty_1 : dirty_0) ? WB : REFILL;
            end
            WB: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    beat_d   = beat_q + 1'b1;
                    estado_d = beat_q == LAST ? REFILL : WB;
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                data_we = mem_ack;
                if (mem_ack) begin
                    beat_d   = beat_q + 1'b1;
                    estado_d = beat_q == LAST ? FILLTAG : REFILL;
                end
            end
            FILLTAG: begin
                tag_we   = 1'b1;
                code     = FILL;
                estado_d = TOUCH;
            end
            TOUCH: begin
                tag_we   = 1'b1;
                data_we  = we_q;
                code     = we_q ? WR_TOUCH : RD_TOUCH;
                way_d    = !way_q;
                estado_d = LRUCLR;
            end
            LRUCLR: begin
                tag_we   = 1'b1;
                code     = CLR_LRU;
                estado_d = DONE;
            end
            DONE: begin
                cpu_ready = 1'b1;
                estado_d  = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    assign {uso, sel_mux_mem_0, sel_mux_mem_1} = code;
    assign way_sel = way_q;
    assign beat    = beat_q;

    contador_saturado #(.CNT_W(CNT_W)) u_hit (.clk(clk), .rst_n(rst_n), .en_i(hit_en), .cnt_o(hit_cnt));
    contador_saturado #(.CNT_W(CNT_W)) u_miss (.clk(clk), .rst_n(rst_n), .en_i(miss_en), .cnt_o(miss_cnt));
endmodule

// File: tb/tb_controlador_cache_2vias.sv
// tb_controlador_cache_2vias: directed accesses checked each cycle against a transaction-level
// model; a second instance with 2-bit counters exposes counter saturation.
module tb_controlador_cache_2vias;
    logic clk = 0, rst_n = 0, cpu_req = 0, cpu_we = 0, hit_0 = 0, hit_1 = 0;
    logic lru_0 = 0, dirty_0 = 0, dirty_1 = 0, mem_ack = 0;
    logic cpu_ready, way_sel, uso, sel_mux_mem_0, sel_mux_mem_1, tag_we, data_we, mem_req, mem_we;
    logic [1:0] beat;
    logic [15:0] hit_cnt, miss_cnt;
    logic s_ready, s_way, s_uso, s_m0, s_m1, s_tw, s_dw, s_mr, s_mw;
    logic [1:0] s_beat, s_hit, s_miss;
    int errors = 0, checks = 0, hits = 0, misses = 0, cyc = 0, ready_at = -1;
    logic last_way = 0, chk_en = 0;
    logic [10:0] exp_v = '0;

    controlador_cache_2vias #(.WORDS_LINE(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ready(cpu_ready),
        .hit_0(hit_0), .hit_1(hit_1), .lru_0(lru_0), .dirty_0(dirty_0), .dirty_1(dirty_1),
        .way_sel(way_sel), .uso(uso), .sel_mux_mem_0(sel_mux_mem_0), .sel_mux_mem_1(sel_mux_mem_1),
        .tag_we(tag_we), .data_we(data_we), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .beat(beat), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

    controlador_cache_2vias #(.WORDS_LINE(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ready(s_ready),
        .hit_0(hit_0), .hit_1(hit_1), .lru_0(lru_0), .dirty_0(dirty_0), .dirty_1(dirty_1),
        .way_sel(s_way), .uso(s_uso), .sel_mux_mem_0(s_m0), .sel_mux_mem_1(s_m1),
        .tag_we(s_tw), .data_we(s_dw), .mem_req(s_mr), .mem_we(s_mw), .mem_ack(mem_ack),
        .beat(s_beat), .hit_cnt(s_hit), .miss_cnt(s_miss));

    always #5 clk = ~clk;

    function automatic int sat(input int n, input int w);
        int m = (1 << w) - 1;
        return n > m ? m : n;
    endfunction

    function automatic logic [10:0] vec(input logic rdy, w, input logic [2:0] c,
                                        input logic tw, dw, mr, mw, input int b);
        return {rdy, w, c, tw, dw, mr, mw, 2'(b)};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) assert (!(hit_0 && hit_1));

    always @(negedge clk) if (chk_en) begin
        cyc++;
        if (cpu_ready && ready_at < 0) ready_at = cyc;
        check("outputs", {cpu_ready, way_sel, uso, sel_mux_mem_0, sel_mux_mem_1, tag_we, data_we,
                          mem_req, mem_we, beat}, exp_v);
        check("outputs_small", {s_ready, s_way, s_uso, s_m0, s_m1, s_tw, s_dw, s_mr, s_mw, s_beat}, exp_v);
        check("hit_cnt", hit_cnt, sat(hits, 16));
        check("miss_cnt", miss_cnt, sat(misses, 16));
        check("hit_cnt_sat2", s_hit, sat(hits, 2));
        check("miss_cnt_sat2", s_miss, sat(misses, 2));
    end

    task automatic step(input logic [10:0] v);
        exp_v = v;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic w, input logic wb, input int gap);
        for (int b = 0; b < 4; b++) begin
            repeat (gap) begin
                mem_ack = 0;
                step(vec(0, w, 3'b000, 0, 0, 1, wb, b));
            end
            mem_ack = 1;
            step(vec(0, w, 3'b000, 0, !wb, 1, wb, b));
        end
        mem_ack = 0;
    endtask

    // expected cycle stream follows from the access rules; lat is the hand-computed ready cycle
    task automatic access(input logic we, h0, h1, lru, d0, d1, input int gap, input int lat);
        logic w;
        cpu_req = 1; cpu_we = we; hit_0 = h0; hit_1 = h1; lru_0 = lru; dirty_0 = d0; dirty_1 = d1;
        cyc = -1; ready_at = -1;
        step(vec(0, last_way, 3'b000, 0, 0, 0, 0, 0));
        step(vec(0, last_way, 3'b000, 0, 0, 0, 0, 0));
        if (h0 || h1) begin
            hits++;
            w = !h0;
        end else begin
            misses++;
            w = lru;
            if (lru ? d1 : d0) burst(w, 1, gap);
            burst(w, 0, gap);
            step(vec(0, w, 3'b101, 1, 0, 0, 0, 0));
        end
        step(vec(0, w, we ? 3'b110 : 3'b111, 1, we, 0, 0, 0));
        step(vec(0, !w, 3'b001, 1, 0, 0, 0, 0));
        step(vec(1, !w, 3'b000, 0, 0, 0, 0, 0));
        cpu_req = 0; hit_0 = 0; hit_1 = 0;
        last_way = !w;
        check("latency", ready_at, lat);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {cpu_ready, way_sel, uso, sel_mux_mem_0, sel_mux_mem_1, tag_we,
                                data_we, mem_req, mem_we, beat}, 0);
        check("reset_counters", {hit_cnt, miss_cnt}, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk) #1;
        chk_en = 1;
        access(0, 0, 1, 0, 0, 0, 0, 4);
        check("read_hit_cnt", hit_cnt, 1);
        check("read_hit_way_after", way_sel, 0);
        access(1, 1, 0, 1, 1, 1, 0, 4);
        check("write_hit_miss_cnt", miss_cnt, 0);
        access(0, 0, 0, 0, 0, 1, 1, 13);
        check("clean_miss_cnt", miss_cnt, 1);
        check("clean_miss_way_after", way_sel, 1);
        access(1, 0, 0, 1, 0, 1, 0, 13);
        check("dirty_miss_cnt", miss_cnt, 2);
        // abandon a refill at beat 2 with an asynchronous reset
        cpu_req = 1; cpu_we = 0; lru_0 = 0; dirty_0 = 0; dirty_1 = 0;
        step(vec(0, last_way, 3'b000, 0, 0, 0, 0, 0));
        step(vec(0, last_way, 3'b000, 0, 0, 0, 0, 0));
        misses++;
        mem_ack = 1;
        step(vec(0, 0, 3'b000, 0, 1, 1, 0, 0));
        step(vec(0, 0, 3'b000, 0, 1, 1, 0, 1));
        chk_en = 0;
        check("beat_before_reset", beat, 2);
        #2 rst_n = 0;
        #1;
        check("async_reset_outputs", {cpu_ready, way_sel, uso, sel_mux_mem_0, sel_mux_mem_1,
                                      tag_we, data_we, mem_req, mem_we, beat}, 0);
        check("async_reset_counters", {hit_cnt, miss_cnt, s_hit, s_miss}, 0);
        cpu_req = 0;
        repeat (2) begin
            @(negedge clk);
            check("reset_no_mem_req", mem_req, 0);
        end
        rst_n = 1;
        @(posedge clk) #1;
        hits = 0; misses = 0; last_way = 0; chk_en = 1;
        step(vec(0, 0, 3'b000, 0, 0, 0, 0, 0));
        mem_ack = 0;
        step(vec(0, 0, 3'b000, 0, 0, 0, 0, 0));
        access(0, 1, 0, 0, 0, 0, 0, 4);
        access(1, 0, 1, 1, 0, 0, 0, 4);
        access(0, 0, 1, 0, 1, 0, 0, 4);
        access(1, 1, 0, 0, 0, 0, 0, 4);
        check("sat_small_hit_cnt", s_hit, 3);
        check("wide_hit_cnt", hit_cnt, 4);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
